// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared mode and FSM state encodings for stream_mux_rr
// Contents: MODE_SEL/MODE_RR values for the mode input, state_t for the packet-lock FSM
package stream_mux_pkg;
   localparam logic MODE_SEL = 1'b0;
   localparam logic MODE_RR = 1'b1;
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority search starting just above ptr
// Ports: req (per-channel requests), ptr (last served index),
//        gnt_valid (some request found), gnt_idx (winning index)
module rr_arbiter #(
   parameter int N = 4,
   localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic            gnt_valid,
   output logic [SELW-1:0] gnt_idx
);
   logic [SELW-1:0] k;
   // Walk from the lowest priority (ptr itself) up to ptr+1 so the last hit wins.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx = '0;
      k = '0;
      for (int i = N; i >= 1; i--) begin
         k = SELW'((int'(ptr) + i) % N);
         if (req[k]) begin
            gnt_valid = 1'b1;
            gnt_idx = k;
         end
      end
   end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-input W-bit registered stream mux with select or round-robin arbitration
// Ports: clk, rst (async active-high), mode (0 select / 1 round-robin), sel,
//        in_valid/in_data/in_last/in_ready (N producer streams),
//        out_valid/out_data/out_last/out_src/out_ready (single consumer stream)
// Build option: define STREAM_MUX_PKT_LOCK_EN to hold the grant for a whole packet;
//               otherwise every beat is arbitrated independently.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter int N = 4,
   parameter int W = 8,
   localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            mode,
   input  logic [SELW-1:0] sel,
   input  logic [N-1:0]    in_valid,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_last,
   output logic [N-1:0]    in_ready,
   output logic            out_valid,
   output logic [W-1:0]    out_data,
   output logic            out_last,
   output logic [SELW-1:0] out_src,
   input  logic            out_ready
);
   logic [SELW-1:0] ptr, g, idle_g, arb_idx;
   logic [N-1:0] bit_g;
   logic arb_valid, sel_ok, idle_gv, gv, can_load, acc, g_last, ptr_upd;

   rr_arbiter #(.N(N)) u_arb (
      .req(in_valid),
      .ptr(ptr),
      .gnt_valid(arb_valid),
      .gnt_idx(arb_idx)
   );

   // Shift-based bit picks stay in range even when sel exceeds N-1.
   assign sel_ok = (int'(sel) < N) && |(in_valid & (N'(1) << sel));
   assign idle_gv = (mode == MODE_RR) ? arb_valid : sel_ok;
   assign idle_g = (mode == MODE_RR) ? arb_idx : sel;

`ifdef STREAM_MUX_PKT_LOCK_EN
   state_t state, state_d;
   logic [SELW-1:0] lock_g, lock_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         lock_g <= '0;
      end else begin
         state <= state_d;
         lock_g <= lock_d;
      end
   end

   always_comb begin
      state_d = state;
      lock_d = lock_g;
      if (acc) begin
         state_d = g_last ? ST_IDLE : ST_LOCKED;
         lock_d = g;
      end
   end

   // While locked the owner keeps its grant even if it idles between beats.
   assign gv = (state == ST_LOCKED) || idle_gv;
   assign g = (state == ST_LOCKED) ? lock_g : idle_g;
   assign ptr_upd = acc && g_last;
`else
   assign gv = idle_gv;
   assign g = idle_g;
   assign ptr_upd = acc;
`endif

   assign bit_g = N'(1) << g;
   assign can_load = !out_valid || out_ready;
   assign acc = gv && can_load && |(in_valid & bit_g);
   assign g_last = |(in_last & bit_g);
   // Gated by rst so nothing is offered upstream while reset is held.
   assign in_ready = (gv && can_load && !rst) ? bit_g : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data <= '0;
         out_last <= 1'b0;
         out_src <= '0;
         ptr <= SELW'(N - 1);
      end else begin
         if (acc) begin
            out_valid <= 1'b1;
            out_data <= in_data[int'(g)*W +: W];
            out_last <= g_last;
            out_src <= g;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (ptr_upd) ptr <= g;
      end
   end
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed vector table, reset sequence and random traffic against a reference model
module tb_stream_mux_rr;
   localparam int N = 4;
   localparam int W = 8;
   localparam logic [N*W-1:0] FIXED = 32'h44332211;
`ifdef STREAM_MUX_PKT_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic clk = 1'b0, rst = 1'b0, mode = 1'b0, out_ready = 1'b0;
   logic [1:0] sel = '0;
   logic [N-1:0] in_valid = '0, in_last = '0;
   logic [N*W-1:0] in_data = '0;
   logic [N-1:0] in_ready;
   logic out_valid, out_last;
   logic [W-1:0] out_data;
   logic [1:0] out_src;

   stream_mux_rr #(.N(N), .W(W)) dut (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int errors = 0, checks = 0;

   logic m_ov, m_last;
   logic [W-1:0] m_data;
   int m_src, m_ptr, m_owner;
   bit m_locked;

   typedef struct {
      logic mode;
      logic [1:0] sel;
      logic [3:0] valid, last;
      logic ordy;
      logic [3:0] rdy;
      logic ov;
      logic [1:0] src;
   } vec_t;
   vec_t tv[$];

   function automatic vec_t mk(logic md, logic [1:0] s, logic [3:0] v, logic [3:0] l,
                               logic r, logic [3:0] er, logic eov, logic [1:0] es);
      vec_t x;
      x.mode = md; x.sel = s; x.valid = v; x.last = l; x.ordy = r;
      x.rdy = er; x.ov = eov; x.src = es;
      return x;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ov = 1'b0; m_last = 1'b0; m_data = '0; m_src = 0;
      m_ptr = N - 1; m_owner = 0; m_locked = 1'b0;
   endtask

   // Channel the rules grant this cycle, or -1.
   function automatic int mgrant();
      if (m_locked) return m_owner;
      if (mode == 1'b0) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
      for (int k = 1; k <= N; k++)
         if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] mready(int g);
      logic [N-1:0] r;
      r = '0;
      if (g >= 0 && (!m_ov || out_ready)) r[g] = 1'b1;
      return r;
   endfunction

   task automatic cycle();
      int g;
      #1;
      g = mgrant();
      check("in_ready", in_ready, mready(g));
      @(posedge clk);
      if (g >= 0 && (!m_ov || out_ready) && in_valid[g]) begin
         m_ov = 1'b1;
         m_data = in_data[g*W +: W];
         m_last = in_last[g];
         m_src = g;
         if (LOCK && !in_last[g]) begin
            m_locked = 1'b1;
            m_owner = g;
         end else begin
            m_locked = 1'b0;
            m_ptr = g;
         end
      end else if (out_ready) begin
         m_ov = 1'b0;
      end
      #1;
      check("out_valid", out_valid, m_ov);
      check("out_data", out_data, m_data);
      check("out_last", out_last, m_last);
      check("out_src", out_src, m_src);
   endtask

   initial begin
      #1 rst = 1'b1;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_src", out_src, 0);
      check("rst_in_ready", in_ready, 0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;

      // round-robin, single-beat packets
      tv.push_back(mk(1, 0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 0));
      tv.push_back(mk(1, 0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 1));
      tv.push_back(mk(1, 0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 2));
      tv.push_back(mk(1, 0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 3));
      tv.push_back(mk(1, 0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 0));
      // explicit select
      tv.push_back(mk(0, 2, 4'b1111, 4'b1111, 1, 4'b0100, 1, 2));
      tv.push_back(mk(0, 2, 4'b1111, 4'b1111, 1, 4'b0100, 1, 2));
      tv.push_back(mk(0, 3, 4'b0111, 4'b1111, 1, 4'b0000, 0, 2));
      // round-robin resumes after ptr = 2
      tv.push_back(mk(1, 0, 4'b1111, 4'b1111, 1, 4'b1000, 1, 3));
      // backpressure then drain + reload
      for (int i = 0; i < 5; i++) tv.push_back(mk(1, 0, 4'b1111, 4'b1111, 0, 4'b0000, 1, 3));
      tv.push_back(mk(1, 0, 4'b1111, 4'b1111, 1, 4'b0001, 1, 0));
`ifdef STREAM_MUX_PKT_LOCK_EN
      tv.push_back(mk(1, 0, 4'b1111, 4'b1101, 1, 4'b0010, 1, 1));
      tv.push_back(mk(0, 3, 4'b1111, 4'b1101, 1, 4'b0010, 1, 1));
      tv.push_back(mk(0, 0, 4'b1111, 4'b1111, 1, 4'b0010, 1, 1));
      tv.push_back(mk(1, 0, 4'b1111, 4'b1111, 1, 4'b0100, 1, 2));
`else
      tv.push_back(mk(1, 0, 4'b1111, 4'b1101, 1, 4'b0010, 1, 1));
      tv.push_back(mk(1, 0, 4'b1111, 4'b1101, 1, 4'b0100, 1, 2));
      tv.push_back(mk(1, 0, 4'b1111, 4'b1101, 1, 4'b1000, 1, 3));
      tv.push_back(mk(1, 0, 4'b1111, 4'b1101, 1, 4'b0001, 1, 0));
`endif
      in_data = FIXED;
      foreach (tv[i]) begin
         mode = tv[i].mode; sel = tv[i].sel; in_valid = tv[i].valid;
         in_last = tv[i].last; out_ready = tv[i].ordy;
         #1;
         check($sformatf("tbl%0d_rdy", i), in_ready, tv[i].rdy);
         cycle();
         check($sformatf("tbl%0d_ov", i), out_valid, tv[i].ov);
         check($sformatf("tbl%0d_src", i), out_src, tv[i].src);
         check($sformatf("tbl%0d_data", i), out_data, 8'h11 * (tv[i].src + 1));
      end

      // reset in the middle of a ch2 packet
      mode = 1'b1; in_valid = 4'b0100; in_last = 4'b0000; out_ready = 1'b1;
      cycle();
      #2 rst = 1'b1;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_out_src", out_src, 0);
      check("mid_rst_in_ready", in_ready, 0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      in_valid = 4'b1111; in_last = 4'b1111;
      cycle();
      check("post_rst_src", out_src, 0);
      check("post_rst_data", out_data, 8'h11);

      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 9) == 0) mode = ~mode;
         sel = 2'($urandom_range(0, 3));
         in_valid = 4'($urandom);
         in_last = 4'($urandom);
         in_data = 32'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
